// File: rtl/rf_write_port_arbiter.sv
// Register-file write-port arbiter: writeback has priority over buffered MDU results.
// MDU results go through a FIFO and drain on cycles without a writeback request.
// Optional starvation guard enabled by defining STARVE_GUARD_EN.
module rf_write_port_arbiter #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [ADDR_W-1:0]                 wb_rd_addr,
    input  logic                              wb_rd_we,
    input  logic [DATA_W-1:0]                 wb_rd_data,
    input  logic                              mdu_valid,
    output logic                              mdu_ready,
    input  logic [ADDR_W-1:0]                 mdu_rd_addr,
    input  logic [DATA_W-1:0]                 mdu_rd_data,
    output logic [ADDR_W-1:0]                 rf_waddr,
    output logic                              rf_we,
    output logic [DATA_W-1:0]                 rf_wdata,
    output logic                              pipe_stall,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [ADDR_W-1:0] addr_mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] data_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

    logic fifo_empty, fifo_full;
    logic push, store, pop, wb_req;
    logic stall_active;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign mdu_ready  = !rst && !fifo_full;
    assign push       = mdu_valid && mdu_ready;
    // Results for x0 complete the handshake but are never written
    assign store      = push && (mdu_rd_addr != '0);
    assign wb_req     = wb_rd_we && (wb_rd_addr != '0);

    // Grant selection: forced drain, then writeback, then FIFO drain
    always_comb begin
        pop        = 1'b0;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (stall_active && !fifo_empty) begin
            pop = 1'b1;
        end else if (wb_req) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = wb_rd_addr;
            rf_wdata_d = wb_rd_data;
        end else if (!fifo_empty) begin
            pop = 1'b1;
        end
        if (pop) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = addr_mem_q[rd_ptr_q];
            rf_wdata_d = data_mem_q[rd_ptr_q];
        end
    end

    // FIFO pointer and occupancy next state
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (store) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (store && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!store && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // FIFO storage; no reset needed since occupancy gates every read
    always_ff @(posedge clk) begin
        if (store) begin
            addr_mem_q[wr_ptr_q] <= mdu_rd_addr;
            data_mem_q[wr_ptr_q] <= mdu_rd_data;
        end
    end

    // Pointer, count and registered write-port state
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

`ifdef STARVE_GUARD_EN
    localparam int SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;

    logic [SW-1:0] starve_q, starve_d;
    logic          stall_q, stall_d;

    // Count cycles with a waiting, unserved entry; a full count forces one stall cycle
    always_comb begin
        starve_d = '0;
        stall_d  = 1'b0;
        if (!pop && !fifo_empty) begin
            if (starve_q == SW'(STARVE_LIMIT - 1)) begin
                stall_d = 1'b1;
            end else begin
                starve_d = starve_q + SW'(1);
            end
        end
    end

    // Starve counter and stall register
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    assign stall_active = stall_q;
`else
    assign stall_active = 1'b0;
`endif

    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign pipe_stall = stall_active;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_rf_write_port_arbiter.sv
// Self-checking bench for rf_write_port_arbiter: directed cases plus randomized traffic
// checked every cycle against a queue-based reference model.
module tb_rf_write_port_arbiter;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] wb_rd_addr = '0;
    logic          wb_rd_we = 1'b0;
    logic [DW-1:0] wb_rd_data = '0;
    logic          mdu_valid = 1'b0;
    logic          mdu_ready;
    logic [AW-1:0] mdu_rd_addr = '0;
    logic [DW-1:0] mdu_rd_data = '0;
    logic [AW-1:0] rf_waddr;
    logic          rf_we;
    logic [DW-1:0] rf_wdata;
    logic          pipe_stall;
    logic [$clog2(DEPTH+1)-1:0] fifo_count;

    always #5 clk = ~clk;

    rf_write_port_arbiter #(
        .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .ADDR_W(AW), .DATA_W(DW)
    ) dut (
        .clk(clk), .rst(rst),
        .wb_rd_addr(wb_rd_addr), .wb_rd_we(wb_rd_we), .wb_rd_data(wb_rd_data),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready),
        .mdu_rd_addr(mdu_rd_addr), .mdu_rd_data(mdu_rd_data),
        .rf_waddr(rf_waddr), .rf_we(rf_we), .rf_wdata(rf_wdata),
        .pipe_stall(pipe_stall), .fifo_count(fifo_count)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    int            qa[$];
    logic [DW-1:0] qd[$];
    int            m_starve = 0;
    bit            m_stall  = 0;
    bit            m_we     = 0;
    int            m_addr   = 0;
    logic [DW-1:0] m_data   = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock edge of the architectural rules
    task automatic model_step();
        bit pop;
        bit was_empty;
        bit push;
        if (rst) begin
            qa.delete(); qd.delete();
            m_starve = 0; m_stall = 0; m_we = 0; m_addr = 0; m_data = '0;
            return;
        end
        was_empty = (qa.size() == 0);
        pop = 0;
        if (m_stall && !was_empty) pop = 1;
        else if (wb_rd_we && wb_rd_addr != 0) begin
            m_we = 1; m_addr = int'(wb_rd_addr); m_data = wb_rd_data;
        end else if (!was_empty) pop = 1;
        else m_we = 0;
        if (pop) begin
            m_we = 1; m_addr = qa[0]; m_data = qd[0];
        end
        push = mdu_valid && (qa.size() != DEPTH);
`ifdef STARVE_GUARD_EN
        if (pop || was_empty) begin
            m_starve = 0; m_stall = 0;
        end else if (m_starve == LIMIT - 1) begin
            m_starve = 0; m_stall = 1;
        end else begin
            m_starve++; m_stall = 0;
        end
`endif
        if (pop) begin
            void'(qa.pop_front()); void'(qd.pop_front());
        end
        if (push && mdu_rd_addr != 0) begin
            qa.push_back(int'(mdu_rd_addr)); qd.push_back(mdu_rd_data);
        end
    endtask

    task automatic check_outputs();
        chk("rf_we", 64'(rf_we), 64'(m_we));
        if (m_we) begin
            chk("rf_waddr", 64'(rf_waddr), 64'(m_addr));
            chk("rf_wdata", 64'(rf_wdata), 64'(m_data));
        end
        chk("pipe_stall", 64'(pipe_stall), 64'(m_stall));
        chk("fifo_count", 64'(fifo_count), 64'(qa.size()));
    endtask

    // Called at a falling edge with inputs already driven
    task automatic tick();
        #1;
        chk("mdu_ready", 64'(mdu_ready), 64'(!rst && qa.size() != DEPTH));
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    int order[$];
    int k;

    initial begin
        @(negedge clk);

        // Reset with MDU offering a result
        rst = 1; mdu_valid = 1; mdu_rd_addr = 5'd7; mdu_rd_data = 32'h1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_ready", 64'(mdu_ready), 64'(0));
            chk("rst_we", 64'(rf_we), 64'(0));
            chk("rst_count", 64'(fifo_count), 64'(0));
            chk("rst_stall", 64'(pipe_stall), 64'(0));
        end
        rst = 0; mdu_valid = 0;

        // Writeback write, then writeback to x0
        wb_rd_we = 1; wb_rd_addr = 5'd5; wb_rd_data = 32'hDEADBEEF;
        tick();
        chk("wb_we", 64'(rf_we), 64'(1));
        chk("wb_addr", 64'(rf_waddr), 64'(5));
        chk("wb_data", 64'(rf_wdata), 64'hDEADBEEF);
        wb_rd_addr = 5'd0;
        tick();
        chk("wb_x0_we", 64'(rf_we), 64'(0));
        wb_rd_we = 0;

        // MDU minimum latency
        mdu_valid = 1; mdu_rd_addr = 5'd3; mdu_rd_data = 32'h12345678;
        tick();
        mdu_valid = 0;
        chk("lat_count1", 64'(fifo_count), 64'(1));
        chk("lat_we1", 64'(rf_we), 64'(0));
        tick();
        chk("lat_we2", 64'(rf_we), 64'(1));
        chk("lat_addr", 64'(rf_waddr), 64'(3));
        chk("lat_data", 64'(rf_wdata), 64'h12345678);
        chk("lat_count0", 64'(fifo_count), 64'(0));

        // Continuous writeback with five MDU results offered
        wb_rd_we = 1; wb_rd_addr = 5'd1; k = 0;
        order.delete();
        for (int i = 1; i <= 56; i++) begin
            if (i == 51) wb_rd_we = 0;
            mdu_valid   = (k < 5);
            mdu_rd_addr = AW'(10 + k);
            mdu_rd_data = 32'hA000 + 32'(k);
            if (mdu_valid && qa.size() != DEPTH) k++;
            tick();
            if (rf_we && rf_waddr >= 5'd10) order.push_back(int'(rf_waddr));
`ifdef STARVE_GUARD_EN
            if (i == 4)  chk("full_ready", 64'(mdu_ready), 64'(0));
            if (i == 9)  chk("guard_stall", 64'(pipe_stall), 64'(1));
            if (i == 10) begin
                chk("guard_drain_addr", 64'(rf_waddr), 64'(10));
                chk("guard_stall_off", 64'(pipe_stall), 64'(0));
            end
`else
            if (i == 50) begin
                chk("busy_count", 64'(fifo_count), 64'(4));
                chk("busy_ready", 64'(mdu_ready), 64'(0));
                chk("busy_stall", 64'(pipe_stall), 64'(0));
            end
            if (i == 51) chk("first_drain_addr", 64'(rf_waddr), 64'(10));
`endif
        end
        mdu_valid = 0;
        chk("drain_n", 64'(order.size()), 64'(5));
        for (int j = 0; j < 5; j++)
            chk("drain_order", 64'((j < order.size()) ? order[j] : -1), 64'(10 + j));
        chk("drain_empty", 64'(fifo_count), 64'(0));

        // Push to x0: handshake completes, nothing stored or written
        wb_rd_we = 0; mdu_valid = 1; mdu_rd_addr = 5'd0; mdu_rd_data = 32'hFFFF;
        #1 chk("x0_ready", 64'(mdu_ready), 64'(1));
        @(negedge clk);
        tick();
        mdu_valid = 0;
        chk("x0_count", 64'(fifo_count), 64'(0));
        tick();
        chk("x0_we", 64'(rf_we), 64'(0));

        // Reset while holding three entries
        wb_rd_we = 1; wb_rd_addr = 5'd2;
        for (int j = 0; j < 3; j++) begin
            mdu_valid = 1; mdu_rd_addr = AW'(20 + j); mdu_rd_data = 32'(j);
            tick();
        end
        mdu_valid = 0;
        chk("pre_rst_count", 64'(fifo_count), 64'(3));
        rst = 1;
        tick();
        chk("mid_rst_count", 64'(fifo_count), 64'(0));
        chk("mid_rst_we", 64'(rf_we), 64'(0));
        rst = 0; wb_rd_we = 0;
        tick();
        chk("post_rst_we", 64'(rf_we), 64'(0));

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 199) == 0);
            wb_rd_we    = ($urandom_range(0, 9) < 8);
            wb_rd_addr  = AW'($urandom_range(0, 31));
            wb_rd_data  = $urandom;
            mdu_valid   = ($urandom_range(0, 3) == 0);
            mdu_rd_addr = AW'($urandom_range(0, 31));
            mdu_rd_data = $urandom;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
